// File: rtl/subservient_gpio_uart_rx.sv
// 8N1 serial receiver with a small byte FIFO and sticky error flags.
// Optional input synchroniser: define SUBSERVIENT_UART_RX_SYNC_EN for pad-driven lines.
module subservient_gpio_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overflow,
  input  logic       i_clr
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   CNT_MAX  = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic rx_s;
  logic rx_prev;

`ifdef SUBSERVIENT_UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  // Two-flop synchroniser, idle-high reset value
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) rx_sync <= 2'b11;
    else             rx_sync <= {rx_sync[0], i_rx};
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = i_rx;
`endif

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            cnt_clr, shift_en, bit_clr, push, ferr_set;

  // FSM state register
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) state <= S_IDLE;
    else             state <= state_n;
  end

  // Next-state and sampling strobes
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    bit_clr  = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s && rx_prev) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          if (!rx_s) begin
            state_n = S_DATA;
            bit_clr = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (state_n != state) cnt_clr = 1'b1;
  end

  // Bit timing counter, bit index, shift register and busy flag
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      o_busy  <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      cnt     <= cnt_clr ? '0 : cnt + CW'(1);
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
      o_busy <= (state_n != S_IDLE);
    end
  end

  logic [7:0]  mem   [DEPTH];
  logic [7:0]  mem_n [DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [PW:0]   count, count_n;
  logic          full, do_pop, push_ok, ovf_set;

  assign full    = (count == CNT_MAX);
  assign do_pop  = o_valid & i_ready;
  assign push_ok = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  // FIFO next-state: a push into a full FIFO is allowed when the head leaves this cycle
  always_comb begin
    mem_n    = mem;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    if (push_ok) begin
      mem_n[wr_ptr] = shreg;
      wr_ptr_n      = wr_ptr + PW'(1);
    end
    if (do_pop) rd_ptr_n = rd_ptr + PW'(1);
    unique case ({push_ok, do_pop})
      2'b10:   count_n = count + (PW + 1)'(1);
      2'b01:   count_n = count - (PW + 1)'(1);
      default: count_n = count;
    endcase
  end

  // FIFO storage, pointers and registered head/valid outputs
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      mem     <= mem_n;
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count   <= count_n;
      o_data  <= mem_n[rd_ptr_n];
      o_valid <= (count_n != '0);
    end
  end

  // Sticky flags; a set event wins over a simultaneous clear
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_frame_err <= ferr_set | (o_frame_err & ~i_clr);
      o_overflow  <= ovf_set  | (o_overflow  & ~i_clr);
    end
  end

endmodule

// File: tb/tb_subservient_gpio_uart_rx.sv
// Directed self-checking bench for subservient_gpio_uart_rx (CLKS_PER_BIT=8, DEPTH=4).
module tb_subservient_gpio_uart_rx;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic       clr   = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overflow;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int start_cyc = 0;

  subservient_gpio_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (ready),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err),
    .o_overflow (o_overflow),
    .i_clr      (clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Drive one 10-bit frame, each bit held CPB cycles; line left at the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h busy=%b want 0 00 0", o_valid, o_data, o_busy);
    end
    checks++;
    if (o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got ferr=%b ovf=%b want 0 0", o_frame_err, o_overflow);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle: got valid=%b busy=%b data=%h want 0 0 00", o_valid, o_busy, o_data);
    end
  endtask

  task automatic test_single_byte();
    bit         found;
    int         seen_cyc;
    logic [7:0] seen_data;
    logic       next_valid;
    found = 1'b0; seen_cyc = 0; seen_data = 8'h00; next_valid = 1'b1;
    ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 200 && !found; i++) begin
          @(posedge clk); #1;
          if (o_valid === 1'b1) begin
            found     = 1'b1;
            seen_cyc  = cyc;
            seen_data = o_data;
          end
        end
        if (found) begin
          @(posedge clk); #1;
          next_valid = o_valid;
        end
      end
    join
    ready = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL single_valid: got no o_valid within 200 cycles want a pulse");
    end
    checks++;
    if (seen_cyc !== start_cyc + 77) begin
      failures++;
      $display("FAIL single_latency: got valid at cycle offset %0d want 77", seen_cyc - start_cyc);
    end
    checks++;
    if (seen_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_data: got %h want a5", seen_data);
    end
    checks++;
    if (next_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse: got valid=%b one cycle later want 0", next_valid);
    end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    checks++;
    if (o_overflow !== 1'b0 || o_valid !== 1'b1 || o_data !== 8'h01) begin
      failures++;
      $display("FAIL ovf_fill4: got ovf=%b valid=%b data=%h want 0 1 01", o_overflow, o_valid, o_data);
    end
    send_frame(8'h05, 1'b1);
    checks++;
    if (o_overflow !== 1'b1 || o_data !== 8'h01) begin
      failures++;
      $display("FAIL ovf_fifth: got ovf=%b data=%h want 1 01", o_overflow, o_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'(i + 1)) begin
        failures++;
        $display("FAIL ovf_pop%0d: got valid=%b data=%h want 1 %h", i, o_valid, o_data, 8'(i + 1));
      end
      pop_one();
    end
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_empty: got valid=%b want 0", o_valid);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%b want 0", o_overflow);
    end
  endtask

  task automatic test_frame_err();
    ready = 1'b0;
    send_frame(8'h3A, 1'b0);
    repeat (20 * CPB) @(posedge clk);
    #1;
    checks++;
    if (o_frame_err !== 1'b1 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL ferr_break: got ferr=%b busy=%b valid=%b want 1 1 0", o_frame_err, o_busy, o_valid);
    end
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ferr_release: got busy=%b valid=%b ovf=%b want 0 0 0", o_busy, o_valid, o_overflow);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (o_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL ferr_clear: got ferr=%b want 0", o_frame_err);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    rx = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx = 1'b1;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_rise: got busy=%b want 1", o_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_hold: got busy=%b at T0+3 want 1", o_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_abort: got busy=%b at T0+4 want 0", o_busy);
    end
    repeat (CPB * 12) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_overflow !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_quiet: got valid=%b ferr=%b ovf=%b busy=%b want 0 0 0 0",
               o_valid, o_frame_err, o_overflow, o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    ready = 1'b0;
    send_frame(8'h77, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h77) begin
      failures++;
      $display("FAIL rst_pre_byte: got valid=%b data=%h want 1 77", o_valid, o_data);
    end
    fork
      send_frame(8'h3C, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (40) @(posedge clk);
        #2;
        checks++;
        if (o_busy !== 1'b1) begin
          failures++;
          $display("FAIL rst_mid_busy: got busy=%b want 1", o_busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b0 ||
            o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin
          failures++;
          $display("FAIL rst_async: got valid=%b data=%h busy=%b ferr=%b ovf=%b want 0 00 0 0 0",
                   o_valid, o_data, o_busy, o_frame_err, o_overflow);
        end
      end
    join
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h5A) begin
      failures++;
      $display("FAIL rst_next_byte: got valid=%b data=%h want 1 5a", o_valid, o_data);
    end
    pop_one();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_only_one: got valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (76) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
      end
    join
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pushpop_ovf: got ovf=%b want 0", o_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp_q[i]) begin
        failures++;
        $display("FAIL full_order%0d: got valid=%b data=%h want 1 %h", i, o_valid, o_data, exp_q[i]);
      end
      pop_one();
    end
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_drained: got valid=%b want 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_full_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subservient_gpio_uart_rx.md
# subservient_gpio_uart_rx

Serial-frame decoder that consumes the single-bit GPIO line driven by the subservient SoC's bit-banged UART output, or the same signal from a pad. It reconstructs 8N1 frames into bytes, buffers them in a small FIFO, and presents them on a valid/ready byte stream to the on-chip test/debug logic. Frame-error and overflow conditions are reported on sticky flags.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit; minimum 4.
- `DEPTH`, default 4: FIFO entries; a power of two, minimum 2.

- `i_wb_clk`  in  1  clock
- `i_wb_rst_n`  in  1  reset, asynchronous, active-low
- `i_rx`  in  1  serial line (idle high), normally the GPIO output
- `o_data`  out  8  byte at FIFO head
- `o_valid`  out  1  FIFO not empty
- `i_ready`  in  1  consumer accepts head when `o_valid & i_ready`
- `o_busy`  out  1  FSM not in IDLE
- `o_frame_err`  out  1  sticky: stop bit sampled low
- `o_overflow`  out  1  sticky: good frame arrived with FIFO full and no pop
- `i_clr`  in  1  clears both sticky flags

## Operation
- `rx_s` is `i_rx`, optionally synchronised (see Configuration). `rx_prev` is a register of `rx_s` and resets to 1.
- `H = CLKS_PER_BIT/2` (floor). The bit counter width is `$clog2(CLKS_PER_BIT)`; the counter is cleared on every state change and on every sample.
- FSM states:
  - IDLE: when `rx_s == 0 && rx_prev == 1`, go to START.
  - START: at count `H-1`, sample. If the sample is 0, go to DATA. If it is 1 (glitch), go to IDLE.
  - DATA: every `CLKS_PER_BIT` cycles, shift the sample into bit 7 of the shift register (LSB first). After 8 samples, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample.
    - Sample 1: push the byte and go to IDLE.
    - Sample 0: set `o_frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s == 1`, then go to IDLE. A break condition never produces a byte.
- FIFO:
  - `o_data` shows the head entry; `o_valid = count != 0`.
  - Pop on `o_valid & i_ready`.
  - Push when full with a simultaneous pop: the push is accepted and no overflow is flagged.
  - Push when full without a pop: the byte is dropped and `o_overflow` is set.
  - Pointers wrap modulo `DEPTH`.
  - `i_ready` with an empty FIFO has no effect.
- Sticky flags: `i_clr` clears them. If a set event occurs in the same cycle as `i_clr`, the set wins.
- Reset takes effect immediately and asynchronously, including mid-frame. A partial frame is lost. After release, a new frame needs a fresh falling edge.

## Timing
- Reset values:
  - outputs: `o_data=8'h00`, `o_valid=0`, `o_busy=0`, `o_frame_err=0`, `o_overflow=0`
  - internal: FSM=IDLE, FIFO storage all 0, pointers and count 0.
- Let T0 be the first rising edge at which `rx_s` is sampled 0 while in IDLE. FSM is in START after T0.
- Start sample at T0+H. Data bit k (k=0..7) is sampled at T0+H+(k+1)·`CLKS_PER_BIT`. Stop sample at T0+H+9·`CLKS_PER_BIT`.
- The push happens on the stop-sample edge. `o_valid` and `o_data` are updated after that edge.
- `o_busy` rises after T0 and falls after the stop-sample edge (good frame).
- A pop is visible (head advance or `o_valid` drop) after the accepting edge.
- Back-to-back frames: the next start edge may be detected from the cycle after the stop sample.

## Configuration
- `SUBSERVIENT_UART_RX_SYNC_EN`:
  - Defined: `i_rx` passes through a 2-flop synchroniser, both flops reset to 1. All sample times shift +2 cycles relative to `i_rx` transitions. Use this when driven from a pad.
  - Undefined: `rx_s = i_rx` directly, for same-clock GPIO drive.

## Test plan
- Send 0xA5 8N1 with `CLKS_PER_BIT=8`, sync off, `i_ready=1` -> one `o_valid` pulse with `o_data=8'hA5`, rising exactly T0+4+72 cycles.
- Hold `i_ready=0` and send 0x01, 0x02, 0x03, 0x04, 0x05 (DEPTH=4) -> `o_overflow=1` after the 5th stop sample. Popping yields 01, 02, 03, 04, then `o_valid=0`.
- Send a frame with the stop bit low, then hold the line low for 20 bit-times -> `o_frame_err=1`, no byte pushed, `o_busy` stays 1 until the line returns high. Pulse `i_clr` -> flag reads 0.
- Drive a 2-cycle low glitch on an idle line -> START aborts, `o_busy` drops after T0+H, no byte, no flags.
- Assert `i_wb_rst_n=0` mid-DATA of 0x3C, release, then send 0x5A -> only 0x5A appears, all outputs 0 during reset.
- With FIFO full and `i_ready=1` held during the stop-sample cycle of a new frame -> byte accepted, `o_overflow` stays 0, and order is preserved.
